regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 97 +++++++++
 tb/tb_regfile_mp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: register file with two write ports and NUM_RD independent combinational read ports.
// Supports an optional hardwired zero register and same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int WIDTH    = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [WIDTH-1:0]         wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [WIDTH-1:0]         wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*WIDTH-1:0]  rdata,
    output logic                     wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b1}};

    logic [WIDTH-1:0] regs_r [DEPTH];
    logic             wr_conflict_r;
    logic             wen0_s;
    logic             wen1_s;

    // The zero register silently drops writes on either port.
    always_comb begin
        wen0_s = we0;
        wen1_s = we1;
        if ((ZERO_REG == 1) && (waddr0 == ZERO_ADDR)) begin
            wen0_s = 1'b0;
        end else begin
            wen0_s = we0;
        end
        if ((ZERO_REG == 1) && (waddr1 == ZERO_ADDR)) begin
            wen1_s = 1'b0;
        end else begin
            wen1_s = we1;
        end
    end

    // Storage update; port 1 is scheduled last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if (wen0_s) begin
                regs_r[waddr0] <= wdata0;
            end
            if (wen1_s) begin
                regs_r[waddr1] <= wdata1;
            end
        end
    end

    // Collision flag, visible for exactly the cycle after the colliding edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_conflict_r <= 1'b0;
        end else begin
            wr_conflict_r <= we0 && we1 && (waddr0 == waddr1);
        end
    end

    assign wr_conflict = wr_conflict_r;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [WIDTH-1:0]  data_s;

        assign addr_s = raddr[k*ADDR_W +: ADDR_W];

        // Read mux: zero register first, then forwarding (port 1 priority), else stored value.
        always_comb begin
            data_s = regs_r[addr_s];
            if ((ZERO_REG == 1) && (addr_s == ZERO_ADDR)) begin
                data_s = '0;
            end else if ((BYPASS == 1) && !reset && we1 && (waddr1 == addr_s)) begin
                data_s = wdata1;
            end else if ((BYPASS == 1) && !reset && we0 && (waddr0 == addr_s)) begin
                data_s = wdata0;
            end else begin
                data_s = regs_r[addr_s];
            end
        end

        assign rdata[k*WIDTH +: WIDTH] = data_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero-reg+bypass, plain) driven in lockstep,
// checked by a directed vector table, directed sequences and a randomized reference model.
module tb_regfile_mp;

    localparam int W  = 64;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam logic [W-1:0] K = 64'h0000010204080001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           we0;
    logic [AW-1:0]  waddr0;
    logic [W-1:0]   wdata0;
    logic           we1;
    logic [AW-1:0]  waddr1;
    logic [W-1:0]   wdata1;
    logic [NR*AW-1:0] raddr;
    logic [NR*W-1:0]  rdata_a;
    logic [NR*W-1:0]  rdata_b;
    logic           conf_a;
    logic           conf_b;

    regfile_mp #(.WIDTH(W), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_a), .wr_conflict(conf_a)
    );

    regfile_mp #(.WIDTH(W), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_b), .wr_conflict(conf_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: architectural register contents as seen by each instance.
    logic [W-1:0] m_a [32];
    logic [W-1:0] m_b [32];
    logic         m_conf;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_a[i] <= '0;
                m_b[i] <= '0;
            end
            m_conf <= 1'b0;
        end else begin
            if (we0 && !(we1 && waddr1 == waddr0)) begin
                if (waddr0 != 5'd31) m_a[waddr0] <= wdata0;
                m_b[waddr0] <= wdata0;
            end
            if (we1) begin
                if (waddr1 != 5'd31) m_a[waddr1] <= wdata1;
                m_b[waddr1] <= wdata1;
            end
            m_conf <= we0 && we1 && (waddr0 == waddr1);
        end
    end

    function automatic logic [W-1:0] exp_rd(input bit zero, input bit byp,
                                            input logic [AW-1:0] a, input logic [W-1:0] stored);
        if (zero && a == 5'd31) return '0;
        if (byp && !reset && we1 && waddr1 == a) return wdata1;
        if (byp && !reset && we0 && waddr0 == a) return wdata0;
        return stored;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                         input logic e1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        reset = r; we0 = e0; waddr0 = a0; wdata0 = d0;
        we1 = e1; waddr1 = a1; wdata1 = d1;
        raddr = {r1, r0};
    endtask

    task automatic check_model();
        logic [AW-1:0] a;
        for (int k = 0; k < NR; k++) begin
            a = raddr[k*AW +: AW];
            chk($sformatf("rnd_a_rd%0d", k), rdata_a[k*W +: W], exp_rd(1'b1, 1'b1, a, m_a[a]));
            chk($sformatf("rnd_b_rd%0d", k), rdata_b[k*W +: W], exp_rd(1'b0, 1'b0, a, m_b[a]));
        end
        chk("rnd_a_conf", {63'd0, conf_a}, {63'd0, m_conf});
        chk("rnd_b_conf", {63'd0, conf_b}, {63'd0, m_conf});
    endtask

    typedef struct {
        logic rst; logic we0; logic [AW-1:0] wa0; logic [W-1:0] wd0;
        logic we1; logic [AW-1:0] wa1; logic [W-1:0] wd1;
        logic [AW-1:0] ra0; logic [AW-1:0] ra1;
        logic [W-1:0] ea0; logic [W-1:0] ea1; logic eca;
        logic [W-1:0] eb0; logic [W-1:0] eb1; logic ecb;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd0, 5'd31, 64'h0,    64'h0,    1'b0, 64'h0,    64'h0,    1'b0};
        tbl[1]  = '{1'b0, 1'b1, 5'd3,  64'hAAAA, 1'b1, 5'd7,  64'h5555, 5'd3, 5'd7,  64'hAAAA, 64'h5555, 1'b0, 64'h0,    64'h0,    1'b0};
        tbl[2]  = '{1'b0, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd3, 5'd7,  64'hAAAA, 64'h5555, 1'b0, 64'hAAAA, 64'h5555, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 5'd9,  64'h1111, 1'b1, 5'd9,  64'h2222, 5'd9, 5'd9,  64'h2222, 64'h2222, 1'b0, 64'h0,    64'h0,    1'b0};
        tbl[4]  = '{1'b0, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd9, 5'd3,  64'h2222, 64'hAAAA, 1'b1, 64'h2222, 64'hAAAA, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd9, 5'd9,  64'h2222, 64'h2222, 1'b0, 64'h2222, 64'h2222, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 5'd5,  64'hDEAD, 1'b0, 5'd0,  64'h0,    5'd5, 5'd5,  64'hDEAD, 64'hDEAD, 1'b0, 64'h0,    64'h0,    1'b0};
        tbl[7]  = '{1'b0, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd5, 5'd5,  64'hDEAD, 64'hDEAD, 1'b0, 64'hDEAD, 64'hDEAD, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0,  64'h0,    5'd31, 5'd31, 64'h0,   64'h0,    1'b0, 64'h0,    64'h0,    1'b0};
        tbl[9]  = '{1'b0, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd31, 5'd31, 64'h0,   64'h0,    1'b0, 64'hFFFF, 64'hFFFF, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 5'd0,  64'h0,    1'b1, 5'd31, 64'h1234, 5'd31, 5'd31, 64'h0,   64'h0,    1'b0, 64'hFFFF, 64'hFFFF, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd31, 5'd31, 64'h0,   64'h0,    1'b0, 64'h1234, 64'h1234, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 5'd2,  64'h42,   1'b0, 5'd0,  64'h0,    5'd2, 5'd2,  64'h42,   64'h42,   1'b0, 64'h0,    64'h0,    1'b0};
        tbl[13] = '{1'b1, 1'b1, 5'd2,  64'h99,   1'b1, 5'd2,  64'h77,   5'd2, 5'd3,  64'h42,   64'hAAAA, 1'b0, 64'h42,   64'hAAAA, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd2, 5'd3,  64'h0,    64'h0,    1'b0, 64'h0,    64'h0,    1'b0};
        tbl[15] = '{1'b0, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd9, 5'd5,  64'h0,    64'h0,    1'b0, 64'h0,    64'h0,    1'b0};

        // Initial reset (no checks: storage is undefined until the first reset edge).
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;

        // Directed vector table: outputs sampled mid-cycle, before the row's edge.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].rst, tbl[i].we0, tbl[i].wa0, tbl[i].wd0, tbl[i].we1, tbl[i].wa1, tbl[i].wd1,
                  tbl[i].ra0, tbl[i].ra1);
            @(negedge clk);
            chk($sformatf("tbl%0d_a_rd0", i), rdata_a[0 +: W], tbl[i].ea0);
            chk($sformatf("tbl%0d_a_rd1", i), rdata_a[W +: W], tbl[i].ea1);
            chk($sformatf("tbl%0d_a_conf", i), {63'd0, conf_a}, {63'd0, tbl[i].eca});
            chk($sformatf("tbl%0d_b_rd0", i), rdata_b[0 +: W], tbl[i].eb0);
            chk($sformatf("tbl%0d_b_rd1", i), rdata_b[W +: W], tbl[i].eb1);
            chk($sformatf("tbl%0d_b_conf", i), {63'd0, conf_b}, {63'd0, tbl[i].ecb});
            @(posedge clk);
            #1;
        end

        // Fill reg i with i*K through port 0, checking the forwarded value on instance A.
        for (int i = 0; i < 31; i++) begin
            drive(1'b0, 1'b1, AW'(i), K * W'(i), 1'b0, 5'd0, 64'h0, AW'(i), 5'd31);
            @(negedge clk);
            chk($sformatf("fill%0d_a_byp", i), rdata_a[0 +: W], K * W'(i));
            chk($sformatf("fill%0d_a_zero", i), rdata_a[W +: W], 64'h0);
            @(posedge clk);
            #1;
        end

        // Read back pairs (i, i+1); reg 31 reads zero on both instances here.
        for (int i = 0; i < 31; i++) begin
            logic [W-1:0] e1;
            e1 = (i + 1 == 31) ? 64'h0 : K * W'(i + 1);
            drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, AW'(i), AW'(i + 1));
            @(negedge clk);
            chk($sformatf("pair%0d_a_rd0", i), rdata_a[0 +: W], K * W'(i));
            chk($sformatf("pair%0d_a_rd1", i), rdata_a[W +: W], e1);
            chk($sformatf("pair%0d_b_rd0", i), rdata_b[0 +: W], K * W'(i));
            chk($sformatf("pair%0d_b_rd1", i), rdata_b[W +: W], e1);
            @(posedge clk);
            #1;
        end

        // Randomized traffic with address collisions biased in, checked against the model.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] a0, a1, r0, r1;
            a0 = AW'($urandom_range(31));
            a1 = ($urandom_range(3) == 0) ? a0 : AW'($urandom_range(31));
            case ($urandom_range(2))
                0: r0 = a0;
                1: r0 = a1;
                default: r0 = AW'($urandom_range(31));
            endcase
            r1 = ($urandom_range(1) == 0) ? a1 : AW'($urandom_range(31));
            drive(($urandom_range(40) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(1)), a0, {$urandom, $urandom},
                  1'($urandom_range(1)), a1, {$urandom, $urandom}, r0, r1);
            @(negedge clk);
            check_model();
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
